// File: rtl/prio_encoder_q_if.sv
// Request/handshake bundle for prio_encoder_q.
// The master side is the encoder: it takes in request lines and the consumer's
// ready, and presents the encoded index.
interface prio_encoder_q_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
);
    logic [N-1:0] req;
    logic         ready;
    logic         clr_ovr;
    logic [W-1:0] idx;
    logic         valid;
    logic [N-1:0] pending;
    logic         overrun;

    modport master (
        input  req,
        input  ready,
        input  clr_ovr,
        output idx,
        output valid,
        output pending,
        output overrun
    );

    modport slave (
        output req,
        output ready,
        output clr_ovr,
        input  idx,
        input  valid,
        input  pending,
        input  overrun
    );
endinterface

// File: rtl/prio_encoder_q.sv
// Sequential N-to-log2(N) priority encoder.
// Request pulses are captured into sticky pending bits. The highest-index pending
// bit is presented as a binary index over valid/ready, and its pending bit is
// cleared when the consumer accepts it.
module prio_encoder_q #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prio_encoder_q_if.master      bus
);

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StPresent = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] pending_q, pending_d;
    logic         overrun_q, overrun_d;

    logic         valid;
    logic         accept;
    logic [N-1:0] accept_mask;
    logic [N-1:0] rem;
    logic         ovr_set;

    // Index of the highest set bit; callers never pass zero.
    function automatic logic [W-1:0] enc(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (v[i]) begin
                r = W'(i);
            end
        end
        return r;
    endfunction

    assign valid = (state_q == StPresent);

    // Accept decode: one-hot of the presented index during a handshake.
    always_comb begin
        accept      = valid && bus.ready;
        accept_mask = '0;
        for (int i = 0; i < int'(N); i++) begin
            accept_mask[i] = accept && (idx_q == W'(i));
        end
        rem = pending_q & ~accept_mask;
    end

    // Pending and overrun next state; a same-cycle request re-arms the accepted bit.
    always_comb begin
        pending_d = rem | bus.req;
        ovr_set   = |(bus.req & rem);
        overrun_d = overrun_q;
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (bus.clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    // Presentation FSM; decisions use the registered pending vector only, so a
    // higher-priority request cannot disturb an index already on the bus.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    idx_d   = enc(pending_q);
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (accept) begin
                    if (|rem) begin
                        idx_d = enc(rem);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            pending_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.idx     = idx_q;
    assign bus.valid   = valid;
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_prio_encoder_q.sv
// Directed bench for prio_encoder_q (N = 4). Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, i.e. they reflect that edge.
module tb_prio_encoder_q;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    prio_encoder_q_if #(.N(4), .W(2)) bus ();

    prio_encoder_q #(.N(4), .W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] pend, input logic vld,
                           input logic [1:0] ix, input logic ovr);
        chk({tag, ".pending"}, 8'(bus.pending), 8'(pend));
        chk({tag, ".valid"},   8'(bus.valid),   8'(vld));
        chk({tag, ".idx"},     8'(bus.idx),     8'(ix));
        chk({tag, ".overrun"}, 8'(bus.overrun), 8'(ovr));
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.req     = 4'b1111;
        bus.ready   = 1'b0;
        bus.clr_ovr = 1'b0;

        // Reset held with all requests asserted.
        tick(); chk_all("rst1", 4'b0000, 1'b0, 2'd0, 1'b0);
        tick(); chk_all("rst2", 4'b0000, 1'b0, 2'd0, 1'b0);
        tick(); chk_all("rst3", 4'b0000, 1'b0, 2'd0, 1'b0);
        rst_n   = 1'b1;
        bus.req = 4'b0000;
        tick();
        tick(); chk_all("post_rst", 4'b0000, 1'b0, 2'd0, 1'b0);

        // Single event: pending after one edge, presented after two, gone after three.
        bus.ready = 1'b1;
        bus.req   = 4'b0100;
        tick(); bus.req = 4'b0000;
        chk_all("single_pend", 4'b0100, 1'b0, 2'd0, 1'b0);
        tick(); chk_all("single_pres", 4'b0100, 1'b1, 2'd2, 1'b0);
        tick(); chk_all("single_done", 4'b0000, 1'b0, 2'd2, 1'b0);

        // Priority and drain: 3, 1, 0 back to back.
        bus.req = 4'b1011;
        tick(); bus.req = 4'b0000;
        chk_all("prio_pend", 4'b1011, 1'b0, 2'd2, 1'b0);
        tick(); chk_all("prio_3", 4'b1011, 1'b1, 2'd3, 1'b0);
        tick(); chk_all("prio_1", 4'b0011, 1'b1, 2'd1, 1'b0);
        tick(); chk_all("prio_0", 4'b0001, 1'b1, 2'd0, 1'b0);
        tick(); chk_all("prio_end", 4'b0000, 1'b0, 2'd0, 1'b0);

        // Backpressure: idx 0 held while a higher request arrives.
        bus.ready = 1'b0;
        bus.req   = 4'b0001;
        tick(); bus.req = 4'b0000;
        tick(); chk_all("bp_pres", 4'b0001, 1'b1, 2'd0, 1'b0);
        bus.req = 4'b1000;
        tick(); bus.req = 4'b0000;
        chk_all("bp_hold1", 4'b1001, 1'b1, 2'd0, 1'b0);
        tick(); chk_all("bp_hold2", 4'b1001, 1'b1, 2'd0, 1'b0);
        bus.ready = 1'b1;
        tick(); chk_all("bp_next", 4'b1000, 1'b1, 2'd3, 1'b0);
        tick(); chk_all("bp_end", 4'b0000, 1'b0, 2'd3, 1'b0);

        // Set wins over accept; no overrun for the accepted bit.
        bus.ready = 1'b0;
        bus.req   = 4'b0010;
        tick(); bus.req = 4'b0000;
        tick(); chk_all("sw_pres", 4'b0010, 1'b1, 2'd1, 1'b0);
        bus.req   = 4'b0010;
        bus.ready = 1'b1;
        tick(); bus.req = 4'b0000;
        bus.ready = 1'b0;
        chk_all("sw_accept", 4'b0010, 1'b0, 2'd1, 1'b0);
        tick(); chk_all("sw_repres", 4'b0010, 1'b1, 2'd1, 1'b0);

        // Overrun on a request for an already-pending, unaccepted bit.
        bus.req = 4'b0010;
        tick(); bus.req = 4'b0000;
        chk_all("ovr_set", 4'b0010, 1'b1, 2'd1, 1'b1);
        tick(); chk("ovr_sticky", 8'(bus.overrun), 8'd1);
        // Clear and a new overrun in the same cycle: set wins.
        bus.clr_ovr = 1'b1;
        bus.req     = 4'b0010;
        tick(); bus.req = 4'b0000;
        chk("ovr_setwins", 8'(bus.overrun), 8'd1);
        tick(); bus.clr_ovr = 1'b0;
        chk("ovr_clr", 8'(bus.overrun), 8'd0);
        bus.ready = 1'b1;
        tick(); bus.ready = 1'b0;
        chk_all("ovr_drain", 4'b0000, 1'b0, 2'd1, 1'b0);

        // Reset mid-handshake drops the presented index.
        bus.req = 4'b1010;
        tick(); bus.req = 4'b0000;
        tick(); chk_all("mid_pres", 4'b1010, 1'b1, 2'd3, 1'b0);
        rst_n = 1'b0;
        tick(); chk_all("mid_rst", 4'b0000, 1'b0, 2'd0, 1'b0);
        rst_n     = 1'b1;
        bus.ready = 1'b1;
        tick();
        tick(); chk_all("mid_after", 4'b0000, 1'b0, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_encoder_q.md
# prio_encoder_q

- Sequential N-to-log2(N) priority encoder: the reverse direction of the team's 2-to-4 decoder.
- Captures request pulses into sticky pending bits and presents the highest-index pending request as a binary index.
- Each index is handed off over a valid/ready handshake; the pending bit is cleared on acceptance.
- Sits between event sources (interrupt-style lines) and a consumer that decodes the index back to one-hot.

## Interface

Parameters:
- N, 4, number of request lines; power of two, N >= 2.
- W, 2, index width; must equal log2(N).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req  input  N  request pulses; bit i high in a cycle marks event i pending.
- ready  input  1  consumer accepts the presented index when high together with valid.
- clr_ovr  input  1  clears the overrun flag.
- idx  output  W  encoded index of the presented request.
- valid  output  1  idx is valid and held stable.
- pending  output  N  registered pending vector (status).
- overrun  output  1  sticky flag: a request arrived for an already-pending bit.

## Operation

- Reset (rst_n low at a rising edge) sets all state and outputs to zero:
  - pending = 0, idx = 0, valid = 0, overrun = 0; FSM returns to IDLE.
  - Reset mid-handshake drops the presented index without acceptance.
- Accept event: valid && ready in a cycle. accept_mask is one-hot of idx when an accept occurs, else 0.
- Pending update each edge: pending <= (pending & ~accept_mask) | req.
  - If req sets the bit being accepted in the same cycle, the set wins and the bit stays pending (new event).
- Priority rule: enc(v) is the index of the highest set bit of v (bit N-1 highest). enc(0) is never loaded.
- FSM, two states:
  - IDLE: valid = 0.
    - If registered pending != 0: load idx = enc(pending), set valid = 1, go to PRESENT.
    - Otherwise stay in IDLE; idx holds its last value.
  - PRESENT: valid = 1; idx and valid are held stable while ready is low, even if a higher-priority req arrives.
    - On accept, with rem = pending & ~accept_mask (registered pending only; same-cycle req excluded): if rem != 0, load idx = enc(rem) and stay in PRESENT; else valid = 0 and go to IDLE.
- Overrun: set to 1 at an edge if any bit has req[i] && pending[i] && !accept_mask[i].
  - clr_ovr clears overrun at the edge.
  - If clr_ovr and a new overrun condition occur in the same cycle, the set wins.
- Width rules:
  - idx is exactly W bits, with no truncation since N = 2^W.
  - pending and req are N bits; req bits are treated independently.

## Timing

- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency from req[i] pulse (cycle t, pending empty, FSM in IDLE):
  - pending[i] is set after edge t+1.
  - valid = 1 with idx = i after edge t+2.
- Back-to-back throughput: one index per cycle while ready is held high and rem != 0.
- After the last accept, valid drops at the next edge.
- A request arriving during the final-accept cycle is presented two edges after that accept (one cycle in IDLE).
- ready is ignored while valid = 0.

## Test plan

- Reset: drive req = 4'b1111 with rst_n low for 3 cycles.
  - Required: pending = 0, valid = 0, idx = 0, overrun = 0 throughout, and 2 cycles after release of the last req no spurious state.
- Single event: req = 4'b0100 for one cycle, ready = 1.
  - Required: valid rises 2 edges later with idx = 2; valid falls the next edge; pending returns to 0.
- Priority and drain: req = 4'b1011 in one cycle, ready held high.
  - Required: idx sequence 3, 1, 0 on consecutive cycles with valid continuously high, then valid = 0.
- Stability under backpressure: pending = 4'b0001 presented (idx = 0), ready = 0, then pulse req = 4'b1000.
  - Required: idx stays 0 until ready = 1; the next presented idx = 3.
- Set-wins and overrun: while idx = 1 is presented, pulse req = 4'b0010 with ready = 1.
  - Required: bit 1 remains pending and is re-presented; overrun stays 0.
  - Then pulse req = 4'b0010 again with ready = 0: overrun = 1 at the next edge.
  - clr_ovr for one cycle returns overrun to 0.
- Reset mid-operation: assert rst_n low while valid = 1, idx = 3, pending = 4'b1010.
  - Required: next edge valid = 0, pending = 0, FSM in IDLE; no index is reissued after release.
